// File: rtl/icache_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_responder_if
//  Description : Fetch-side request/response and memory burst-read signals
//                of the instruction cache, bundled with cache/environment views.
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_responder_if;
    logic        stall_icache;
    logic [11:0] icache_idx;
    logic [2:0]  icache_op;
    logic        icache_is_cached;
    logic [31:0] icache_pa;
    logic [31:0] icache_data;
    logic        icache_busy;
    logic        icache_data_valid;
    logic        rd_req;
    logic        rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    // Cache side
    modport slave (
        input  stall_icache, icache_idx, icache_op, icache_is_cached, icache_pa,
        output icache_data, icache_busy, icache_data_valid,
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data
    );

    // Fetch stage plus memory adapter side
    modport master (
        output stall_icache, icache_idx, icache_op, icache_is_cached, icache_pa,
        input  icache_data, icache_busy, icache_data_valid,
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data
    );
endinterface
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icache_responder
//  Description : 2-way set-associative instruction cache, 16 B lines, LRU,
//                burst refill; ICACHE_PERF_CNT_EN adds hit/miss counters.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_responder #(
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 8,
    parameter int TAG_BITS    = 20
) (
    input  wire              clk,
    input  wire              rst_n,
    icache_responder_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int WB    = OFFSET_BITS - 2;
    localparam int WORDS = 1 << WB;
    localparam logic [WB-1:0] c_BEAT_ONE   = WB'(1);
    localparam logic [2:0]    c_OP_FETCH   = 3'd1;
    localparam logic [2:0]    c_OP_IDX_INV = 3'd2;
    localparam logic [2:0]    c_OP_HIT_INV = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MISS   = 3'd2,
        S_REFILL = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [TAG_BITS-1:0] r_tag  [2][SETS];
    logic [31:0]         r_data [2][SETS][WORDS];
    logic [SETS-1:0]     r_valid [2];
    logic [SETS-1:0]     r_lru;

    logic [11:2]   r_idx;
    logic [31:2]   r_pa;
    logic          r_way_sel;
    logic [2:0]    r_op;
    logic          r_cached;
    logic [31:0]   r_resp;
    logic          r_victim;
    logic [WB-1:0] r_beat;

    logic [INDEX_BITS-1:0] w_set;
    logic [WB-1:0]         w_word;
    logic [TAG_BITS-1:0]   w_tag;
    logic [1:0]            w_way_hit;
    logic                  w_hit, w_hit_way, w_victim, w_fetch_hit;
    logic [31:0]           w_hit_word;
    logic                  w_req_ok, w_accept;
    logic                  w_busy, w_dv, w_rd_req, w_rd_type;
    logic [31:0]           w_data, w_rd_addr;
    wire                   w_unused = ^{bus.icache_idx[1:0], bus.icache_pa[1]};

    assign w_set  = r_idx[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign w_word = r_idx[OFFSET_BITS-1:2];
    assign w_tag  = r_pa[31:32-TAG_BITS];

    for (genvar gw = 0; gw < 2; gw++) begin : g_way
        assign w_way_hit[gw] = r_valid[gw][w_set] && (r_tag[gw][w_set] == w_tag);
    end

    assign w_hit       = |w_way_hit;
    assign w_hit_way   = w_way_hit[1];
    assign w_hit_word  = r_data[w_hit_way][w_set][w_word];
    assign w_fetch_hit = (r_op == c_OP_FETCH) && r_cached && w_hit;
    // Invalid ways are filled first (way 0 preferred), otherwise the LRU way
    assign w_victim    = !r_valid[0][w_set] ? 1'b0 :
                         !r_valid[1][w_set] ? 1'b1 : r_lru[w_set];

    assign w_req_ok = (bus.icache_op == c_OP_FETCH) || (bus.icache_op == c_OP_IDX_INV) ||
                      (bus.icache_op == c_OP_HIT_INV);
    assign w_accept = w_req_ok && !w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b0;
        w_dv      = 1'b0;
        w_data    = 32'd0;
        w_rd_req  = 1'b0;
        w_rd_type = 1'b0;
        w_rd_addr = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_req_ok) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_fetch_hit) begin
                    w_dv   = 1'b1;
                    w_data = w_hit_word;
                    if (bus.stall_icache) begin
                        w_busy = 1'b1;
                        w_next = S_RESP;
                    end else begin
                        w_next = w_req_ok ? S_LOOKUP : S_IDLE;
                    end
                end else if (r_op == c_OP_FETCH) begin
                    w_busy = 1'b1;
                    w_next = S_MISS;
                end else begin
                    w_busy = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_MISS: begin
                w_busy    = 1'b1;
                w_rd_req  = 1'b1;
                w_rd_type = r_cached;
                w_rd_addr = r_cached ? {r_pa[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}}
                                     : {r_pa[31:2], 2'b00};
                if (bus.rd_rdy) w_next = S_REFILL;
            end
            S_REFILL: begin
                w_busy = 1'b1;
                if (bus.ret_valid && bus.ret_last) w_next = S_RESP;
            end
            S_RESP: begin
                w_dv   = 1'b1;
                w_data = r_resp;
                w_busy = bus.stall_icache;
                if (!bus.stall_icache) w_next = w_req_ok ? S_LOOKUP : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.icache_busy       = w_busy;
    assign bus.icache_data_valid = w_dv;
    assign bus.icache_data       = w_data;
    assign bus.rd_req            = w_rd_req;
    assign bus.rd_type           = w_rd_type;
    assign bus.rd_addr           = w_rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_lru      <= '0;
            r_idx      <= '0;
            r_pa       <= '0;
            r_way_sel  <= 1'b0;
            r_op       <= 3'd0;
            r_cached   <= 1'b0;
            r_resp     <= 32'd0;
            r_victim   <= 1'b0;
            r_beat     <= '0;
        end else begin
            if (w_accept) begin
                r_idx     <= bus.icache_idx[11:2];
                r_pa      <= bus.icache_pa[31:2];
                r_way_sel <= bus.icache_pa[0];
                r_op      <= bus.icache_op;
                r_cached  <= bus.icache_is_cached;
            end
            case (r_state)
                S_LOOKUP: begin
                    if (w_fetch_hit) begin
                        r_lru[w_set] <= ~w_hit_way;
                        r_resp       <= w_hit_word;
                    end else if (r_op == c_OP_FETCH) begin
                        r_victim <= w_victim;
                    end else if (r_op == c_OP_IDX_INV) begin
                        r_valid[r_way_sel][w_set] <= 1'b0;
                    end else begin
                        if (w_way_hit[0]) r_valid[0][w_set] <= 1'b0;
                        if (w_way_hit[1]) r_valid[1][w_set] <= 1'b0;
                    end
                end
                S_MISS: r_beat <= '0;
                S_REFILL: begin
                    if (bus.ret_valid) begin
                        if (r_cached) begin
                            r_beat <= r_beat + c_BEAT_ONE;
                            if (r_beat == w_word) r_resp <= bus.ret_data;
                            if (bus.ret_last) begin
                                r_valid[r_victim][w_set] <= 1'b1;
                                r_lru[w_set]             <= ~r_victim;
                            end
                        end else begin
                            r_resp <= bus.ret_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays hold no reset so they map onto plain RAM
    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && bus.ret_valid && r_cached) begin
            r_data[r_victim][w_set][r_beat] <= bus.ret_data;
            if (bus.ret_last) r_tag[r_victim][w_set] <= w_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (r_state == S_LOOKUP && w_fetch_hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (r_state == S_LOOKUP && w_next == S_MISS) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_responder
//  Description : Directed bench for icache_responder with a set/way cache
//                model, a memory responder and a per-cycle compare process.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_responder;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    icache_responder_if bus();
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: per set, two ways plus the way to replace next
    logic        m_valid [2][256];
    logic [19:0] m_tag   [2][256];
    logic [31:0] m_line  [2][256][4];
    logic        m_lru   [256];

    logic [31:0] exp_data_q[$];
    logic        exp_rdtype_q[$];
    logic [31:0] exp_rdaddr_q[$];
    logic [31:0] seen_q[$];
    int          seen_cyc[$];
    logic        rdtype_seen[$];
    logic [31:0] rdaddr_seen[$];
    int          beat_no = -1;
    int          last_at = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h1C00000) return 32'hA0 + {30'b0, a[3:2]};
        if (a == 32'h1FE00000) return 32'h12345678;
        return a ^ 32'h5EED0000;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 256; s++) begin
            m_valid[0][s] = 1'b0;
            m_valid[1][s] = 1'b0;
            m_lru[s]      = 1'b0;
        end
        exp_data_q.delete();
        exp_rdtype_q.delete();
        exp_rdaddr_q.delete();
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [31:0] pa, input logic cached);
        int s, hit, v;
        s   = int'(pa[11:4]);
        hit = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][s] && m_tag[w][s] == pa[31:12]) hit = w;
        if (op == 3'd2) begin
            m_valid[pa[0]][s] = 1'b0;
        end else if (op == 3'd3) begin
            if (hit >= 0) m_valid[hit][s] = 1'b0;
        end else if (op == 3'd1 && !cached) begin
            exp_rdtype_q.push_back(1'b0);
            exp_rdaddr_q.push_back({pa[31:2], 2'b00});
            exp_data_q.push_back(mem_word({pa[31:2], 2'b00}));
        end else if (op == 3'd1 && hit >= 0) begin
            exp_data_q.push_back(m_line[hit][s][pa[3:2]]);
            m_lru[s] = (hit == 0);
        end else if (op == 3'd1) begin
            v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : int'(m_lru[s]));
            exp_rdtype_q.push_back(1'b1);
            exp_rdaddr_q.push_back({pa[31:4], 4'h0});
            for (int k = 0; k < 4; k++) m_line[v][s][k] = mem_word({pa[31:4], 2'(k), 2'b00});
            m_tag[v][s]   = pa[31:12];
            m_valid[v][s] = 1'b1;
            m_lru[s]      = (v == 0);
            exp_data_q.push_back(m_line[v][s][pa[3:2]]);
        end
    endtask

    function automatic logic [31:0] obs(input int i);
        return (i < seen_q.size()) ? seen_q[i] : 32'hxxxxxxxx;
    endfunction
    function automatic int obsc(input int i);
        return (i < seen_cyc.size()) ? seen_cyc[i] : -1000;
    endfunction
    function automatic logic [31:0] rda(input int i);
        return (i < rdaddr_seen.size()) ? rdaddr_seen[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic rdt(input int i);
        return (i < rdtype_seen.size()) ? rdtype_seen[i] : 1'bx;
    endfunction

    task automatic clear_obs();
        seen_q.delete();
        seen_cyc.delete();
        rdtype_seen.delete();
        rdaddr_seen.delete();
    endtask

    // Compare process: every consumed response and every read handshake
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) continue;
            if (bus.icache_data_valid && !bus.stall_icache) begin
                seen_q.push_back(bus.icache_data);
                seen_cyc.push_back(cyc);
                if (exp_data_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                else chk("resp_data", bus.icache_data, exp_data_q.pop_front());
            end
            if (bus.rd_req && bus.rd_rdy) begin
                rdtype_seen.push_back(bus.rd_type);
                rdaddr_seen.push_back(bus.rd_addr);
                if (exp_rdaddr_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("rd_type", 32'(bus.rd_type), 32'(exp_rdtype_q.pop_front()));
                    chk("rd_addr", bus.rd_addr, exp_rdaddr_q.pop_front());
                end
            end
        end
    end

    // Memory adapter: accept one cycle after rd_req, then stream beats
    initial begin
        logic [31:0] a;
        logic        t;
        bus.rd_rdy    = 1'b0;
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        bus.ret_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rd_req) begin
                a = bus.rd_addr;
                t = bus.rd_type;
                bus.rd_rdy = 1'b1;
                @(negedge clk);
                bus.rd_rdy = 1'b0;
                for (int k = 0; k < (t ? 4 : 1); k++) begin
                    if (!rst_n) break;
                    bus.ret_valid = 1'b1;
                    bus.ret_last  = (k == (t ? 3 : 0));
                    bus.ret_data  = mem_word(a + 32'(4 * k));
                    beat_no       = k;
                    if (bus.ret_last) last_at = cyc;
                    @(negedge clk);
                end
                bus.ret_valid = 1'b0;
                bus.ret_last  = 1'b0;
                beat_no       = -1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [2:0] op, input logic [31:0] pa, input logic cached,
                         output int waits);
        bus.icache_op        = op;
        bus.icache_pa        = pa;
        bus.icache_idx       = pa[11:0];
        bus.icache_is_cached = cached;
        waits = 0;
        #4;
        while (bus.icache_busy && waits < 200) begin
            @(negedge clk);
            #4;
            waits++;
        end
        chk("issue_accept", 32'(bus.icache_busy), 32'd0);
        if (!bus.icache_busy) model_apply(op, pa, cached);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pa, input logic cached);
        int w;
        issue(3'd1, pa, cached, w);
    endtask

    task automatic drain();
        int n = 0;
        bus.icache_op = 3'd0;
        do begin
            @(negedge clk);
            #4;
            n++;
        end while ((exp_data_q.size() != 0 || bus.icache_busy) && n < 300);
        chk("drain_done", 32'(n < 300), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int w0, w1, w2, n;
        rst_n                = 1'b0;
        bus.stall_icache     = 1'b0;
        bus.icache_op        = 3'd0;
        bus.icache_pa        = 32'd0;
        bus.icache_idx       = 12'd0;
        bus.icache_is_cached = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #3;
        chk("rst_busy",  32'(bus.icache_busy), 32'd0);
        chk("rst_dv",    32'(bus.icache_data_valid), 32'd0);
        chk("rst_data",  bus.icache_data, 32'd0);
        chk("rst_rdreq", 32'(bus.rd_req), 32'd0);
        chk("rst_rdtyp", 32'(bus.rd_type), 32'd0);
        chk("rst_rdadr", bus.rd_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss
        clear_obs();
        fetch(32'h1C000004, 1'b1);
        drain();
        chk("cold_rd_cnt",  32'(rdaddr_seen.size()), 32'd1);
        chk("cold_rd_type", 32'(rdt(0)), 32'd1);
        chk("cold_rd_addr", rda(0), 32'h1C000000);
        chk("cold_data",    obs(0), 32'hA1);
        chk("cold_latency", 32'(obsc(0)), 32'(last_at + 1));

        // Back-to-back hits
        clear_obs();
        issue(3'd1, 32'h1C000000, 1'b1, w0);
        issue(3'd1, 32'h1C000008, 1'b1, w1);
        issue(3'd1, 32'h1C00000C, 1'b1, w2);
        drain();
        chk("b2b_waits",  32'(w0 + w1 + w2), 32'd0);
        chk("b2b_no_rd",  32'(rdaddr_seen.size()), 32'd0);
        chk("b2b_d0",     obs(0), 32'hA0);
        chk("b2b_d1",     obs(1), 32'hA2);
        chk("b2b_d2",     obs(2), 32'hA3);
        chk("b2b_consec", 32'(obsc(2) - obsc(0)), 32'd2);

        // Stall hold, next request taken as stall drops
        clear_obs();
        fetch(32'h1C000004, 1'b1);
        bus.stall_icache = 1'b1;
        bus.icache_pa    = 32'h1C000008;
        bus.icache_idx   = 12'h008;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("stall_dv",   32'(bus.icache_data_valid), 32'd1);
            chk("stall_data", bus.icache_data, 32'hA1);
            chk("stall_busy", 32'(bus.icache_busy), 32'd1);
            @(negedge clk);
        end
        bus.stall_icache = 1'b0;
        #4;
        chk("stall_release_busy", 32'(bus.icache_busy), 32'd0);
        model_apply(3'd1, 32'h1C000008, 1'b1);
        @(negedge clk);
        drain();
        chk("stall_d0", obs(0), 32'hA1);
        chk("stall_d1", obs(1), 32'hA2);

        // Uncached fetch always goes to memory
        clear_obs();
        fetch(32'h1FE00000, 1'b0);
        drain();
        fetch(32'h1FE00000, 1'b0);
        drain();
        chk("unc_rd_cnt",  32'(rdaddr_seen.size()), 32'd2);
        chk("unc_rd_type", 32'(rdt(0)), 32'd0);
        chk("unc_rd_addr", rda(0), 32'h1FE00000);
        chk("unc_d0",      obs(0), 32'h12345678);
        chk("unc_d1",      obs(1), 32'h12345678);

        // LRU victim selection in set 0
        clear_obs();
        fetch(32'h1C001000, 1'b1); drain();
        fetch(32'h1C000000, 1'b1); drain();
        fetch(32'h1C002000, 1'b1); drain();
        fetch(32'h1C000000, 1'b1); drain();
        fetch(32'h1C001000, 1'b1); drain();
        chk("lru_rd_cnt", 32'(rdaddr_seen.size()), 32'd3);
        chk("lru_rd2",    rda(2), 32'h1C001000);
        chk("lru_keep",   obs(3), 32'hA0);

        // Cache operations
        clear_obs();
        issue(3'd3, 32'h1C000000, 1'b1, w0); drain();
        fetch(32'h1C000000, 1'b1); drain();
        chk("hitinv_miss", 32'(rdaddr_seen.size()), 32'd1);
        issue(3'd2, 32'h00000001, 1'b1, w0); drain();
        fetch(32'h1C001000, 1'b1); drain();
        fetch(32'h1C000000, 1'b1); drain();
        chk("idxinv_cnt", 32'(rdaddr_seen.size()), 32'd2);
        chk("idxinv_rd",  rda(1), 32'h1C001000);

        // Reset during refill beat 2
        clear_obs();
        fetch(32'h1C003000, 1'b1);
        bus.icache_op = 3'd0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (beat_no != 2 && n < 100);
        chk("rstmid_reach", 32'(beat_no), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rstmid_rdreq", 32'(bus.rd_req), 32'd0);
        chk("rstmid_dv",    32'(bus.icache_data_valid), 32'd0);
        chk("rstmid_busy",  32'(bus.icache_busy), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_obs();
        fetch(32'h1C000000, 1'b1); drain();
        fetch(32'h1C000000, 1'b1); drain();
        chk("rstmid_refetch_cnt", 32'(rdaddr_seen.size()), 32'd1);
        chk("rstmid_d0", obs(0), 32'hA0);
        chk("rstmid_d1", obs(1), 32'hA0);

        chk("exp_left", 32'(exp_data_q.size() + exp_rdaddr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
